if_fetch_ctrl: RTL and testbench

Instruction-fetch controller that sits between `pc` and the IF/ID pipeline register. It turns the current fetch PC into a request on the instruction bus, which uses a req/ack handshake with variable latency. It presents the returned instruction and its PC to IF/ID, and asks the stall controller to freeze the front end while a fetch is outstanding. It also buffers an instruction that arrives while IF is stalled, and discards in-flight fetches on flush.

---
 rtl/if_fetch_ctrl_pkg.sv | 14 +
 rtl/if_fetch_ctrl.sv | 111 +++++++++++
 tb/tb_if_fetch_ctrl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_ctrl_pkg.sv
// Shared front-end definitions: fetch FSM encoding, NOP word and stall-vector indices.
package cpu_defs;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INST = 32'h0000_0000;
    localparam int          STALL_IF = 1;

endpackage

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: drives a req/ack instruction bus and presents the fetched word to IF/ID.
// Ack-to-inst_o is combinational (0 cycles). Each wait state raises stallreq_o; a stalled IF/ID parks the word in a one-entry buffer.
module if_fetch_ctrl
    import cpu_defs::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic [5:0]  stall,
    input  logic        flush_i,
    output logic        bus_req_o,
    output logic [31:0] bus_addr_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic        inst_valid_o,
    output logic        stallreq_o
);

    fetch_state_t state, state_nxt;
    logic [31:0]  addr_q, addr_nxt;
    logic [31:0]  buf_inst, buf_inst_nxt;
    logic [31:0]  buf_pc, buf_pc_nxt;

    // Only the IF/ID stall bit matters here; the rest of the vector is for other stages.
    logic stall_unused;
    assign stall_unused = ^{stall[5:2], stall[0]};

    always_comb begin
        state_nxt    = state;
        addr_nxt     = addr_q;
        buf_inst_nxt = buf_inst;
        buf_pc_nxt   = buf_pc;
        bus_req_o    = 1'b0;
        bus_addr_o   = 32'h0;
        inst_o       = NOP_INST;
        inst_pc_o    = 32'h0;
        inst_valid_o = 1'b0;
        stallreq_o   = 1'b0;

        case (state)
            IDLE: begin
                state_nxt = BUSY;
            end

            BUSY: begin
                bus_req_o  = 1'b1;
                bus_addr_o = pc_i;
                addr_nxt   = pc_i;
                if (!bus_ack_i) begin
                    stallreq_o = 1'b1;
                    // The request already on the bus must still complete at its old address.
                    if (flush_i) begin
                        state_nxt = DISCARD;
                    end
                end else if (!flush_i) begin
                    inst_o       = bus_rdata_i;
                    inst_pc_o    = pc_i;
                    inst_valid_o = 1'b1;
                    if (stall[STALL_IF]) begin
                        buf_inst_nxt = bus_rdata_i;
                        buf_pc_nxt   = pc_i;
                        state_nxt    = HOLD;
                    end
                end
            end

            HOLD: begin
                if (flush_i) begin
                    state_nxt = BUSY;
                end else begin
                    inst_o       = buf_inst;
                    inst_pc_o    = buf_pc;
                    inst_valid_o = 1'b1;
                    if (!stall[STALL_IF]) begin
                        state_nxt = BUSY;
                    end
                end
            end

            DISCARD: begin
                bus_req_o  = 1'b1;
                bus_addr_o = addr_q;
                stallreq_o = 1'b1;
                if (bus_ack_i) begin
                    state_nxt = BUSY;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            addr_q   <= 32'h0;
            buf_inst <= 32'h0;
            buf_pc   <= 32'h0;
        end else begin
            state    <= state_nxt;
            addr_q   <= addr_nxt;
            buf_inst <= buf_inst_nxt;
            buf_pc   <= buf_pc_nxt;
        end
    end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed scenarios followed by randomized bus latency, IF/ID stalls and flushes.
// The expected fetch-PC stream is queued by the driver and consumed by an independent monitor.
module tb_if_fetch_ctrl;

    logic        clk         = 1'b0;
    logic        rst         = 1'b1;
    logic [31:0] pc_i        = 32'h0;
    logic [5:0]  stall       = 6'h0;
    logic        flush_i     = 1'b0;
    logic        bus_ack_i   = 1'b0;
    logic [31:0] bus_rdata_i = 32'h0;
    logic        bus_req_o;
    logic [31:0] bus_addr_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_valid_o;
    logic        stallreq_o;

    int n_chk  = 0;
    int n_fail = 0;
    int n_pop  = 0;
    bit mon_en = 1'b0;

    // Program-flow model: pc_q is the address of the next instruction the front end owes IF/ID.
    logic [31:0] pc_q       = 32'h0;
    logic [31:0] tgt_q      = 32'h0;
    bit          prev_flush = 1'b0;
    bit          prev_cons  = 1'b0;
    logic [31:0] exp_q[$];

    // Bus slave model.
    bit          out_v     = 1'b0;
    bit          killed    = 1'b0;
    logic [31:0] out_addr  = 32'h0;
    int          wait_left = 0;
    int          wait_n    = 0;

    logic        s_req, s_valid, s_sreq;
    logic [31:0] s_addr, s_inst, s_ipc;
    logic [31:0] zw_data [3] = '{32'h2401_0001, 32'h2402_0002, 32'h2403_0003};

    if_fetch_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .pc_i         (pc_i),
        .stall        (stall),
        .flush_i      (flush_i),
        .bus_req_o    (bus_req_o),
        .bus_addr_o   (bus_addr_o),
        .bus_ack_i    (bus_ack_i),
        .bus_rdata_i  (bus_rdata_i),
        .inst_o       (inst_o),
        .inst_pc_o    (inst_pc_o),
        .inst_valid_o (inst_valid_o),
        .stallreq_o   (stallreq_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        case (a)
            32'h00:  mem = 32'h2401_0001;
            32'h04:  mem = 32'h2402_0002;
            32'h08:  mem = 32'h2403_0003;
            32'h10:  mem = 32'h2402_0005;
            32'h20:  mem = 32'h8C01_0004;
            32'h40:  mem = 32'hDEAD_BEEF;
            default: mem = {a[15:0] ^ 16'hA5C3, a[31:16] + 16'h1357};
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset(input int n);
        mon_en = 1'b0;
        @(negedge clk);
        rst = 1'b1; flush_i = 1'b0; stall = 6'h0; bus_ack_i = 1'b0; pc_i = 32'h0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check("rst_req",      32'(bus_req_o),    32'd0);
            check("rst_addr",     bus_addr_o,        32'd0);
            check("rst_inst",     inst_o,            32'd0);
            check("rst_pc",       inst_pc_o,         32'd0);
            check("rst_valid",    32'(inst_valid_o), 32'd0);
            check("rst_stallreq", 32'(stallreq_o),   32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        out_v = 1'b0; killed = 1'b0; pc_q = 32'h0;
        prev_flush = 1'b0; prev_cons = 1'b0;
        exp_q.delete();
        exp_q.push_back(32'h0);
        mon_en = 1'b1;
        #2;
        check("idle_req", 32'(bus_req_o), 32'd0);
    endtask

    // One clock of stimulus: flush pulse f with redirect target tgt, IF/ID stall s1.
    task automatic cycle(input bit f, input bit s1, input logic [31:0] tgt);
        @(negedge clk);
        if (prev_flush) begin
            pc_q = tgt_q;
            exp_q.delete();
            exp_q.push_back(pc_q);
        end else if (prev_cons) begin
            pc_q = pc_q + 32'd4;
            exp_q.push_back(pc_q);
        end
        pc_i = pc_q; flush_i = f; stall = {4'b0, s1, s1};
        #1;
        if (out_v) begin
            check("req_held",    32'(bus_req_o), 32'd1);
            check("addr_stable", bus_addr_o,     out_addr);
        end else if (bus_req_o) begin
            out_v = 1'b1; out_addr = bus_addr_o; wait_left = wait_n;
        end
        bus_ack_i   = out_v && (wait_left == 0);
        bus_rdata_i = bus_ack_i ? mem(out_addr) : $urandom;
        #1;
        s_req = bus_req_o; s_addr = bus_addr_o; s_valid = inst_valid_o;
        s_inst = inst_o; s_ipc = inst_pc_o; s_sreq = stallreq_o;
        check("stallreq", 32'(stallreq_o), 32'(out_v && (!bus_ack_i || killed)));
        if (killed || f) check("killed_valid", 32'(inst_valid_o), 32'd0);
        prev_flush = f;
        tgt_q      = tgt;
        prev_cons  = inst_valid_o && !s1 && !f;
        if (out_v) begin
            if (bus_ack_i) begin
                out_v = 1'b0; killed = 1'b0;
            end else begin
                wait_left--;
                if (f) killed = 1'b1;
            end
        end
    endtask

    // Monitor: every consumed instruction must be the next one in program order with matching data.
    always @(negedge clk) begin
        logic [31:0] exp_pc;
        #3;
        if (mon_en && !rst) begin
            if (inst_valid_o) begin
                check("inst_data", inst_o, mem(inst_pc_o));
                if (!stall[1] && !flush_i) begin
                    exp_pc = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
                    check("inst_pc_order", inst_pc_o, exp_pc);
                    n_pop++;
                end
            end else begin
                check("nop_inst", inst_o,    32'd0);
                check("nop_pc",   inst_pc_o, 32'd0);
            end
        end
    end

    initial begin
        bit f, s1;
        int last_pop, idle_cyc;

        do_reset(2);

        wait_n = 0;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 32'h0);
            check("zw_addr",  s_addr,          32'(i * 4));
            check("zw_valid", 32'(s_valid),    32'd1);
            check("zw_inst",  s_inst,          zw_data[i]);
            check("zw_pc",    s_ipc,           32'(i * 4));
            check("zw_sreq",  32'(s_sreq),     32'd0);
        end
        cycle(1'b0, 1'b0, 32'h0);

        wait_n = 3;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 32'h0);
            check("ws_sreq",  32'(s_sreq),  32'd1);
            check("ws_addr",  s_addr,       32'h10);
            check("ws_valid", 32'(s_valid), 32'd0);
        end
        cycle(1'b0, 1'b0, 32'h0);
        check("ws_ack_inst", s_inst,       32'h2402_0005);
        check("ws_ack_pc",   s_ipc,        32'h10);
        check("ws_ack_sreq", 32'(s_sreq),  32'd0);

        wait_n = 0;
        cycle(1'b1, 1'b0, 32'h20);
        check("fa_valid", 32'(s_valid), 32'd0);
        check("fa_sreq",  32'(s_sreq),  32'd0);
        cycle(1'b0, 1'b1, 32'h0);
        check("hs_addr",  s_addr,       32'h20);
        check("hs_valid", 32'(s_valid), 32'd1);
        check("hs_inst",  s_inst,       32'h8C01_0004);
        cycle(1'b0, 1'b1, 32'h0);
        check("hold_req",  32'(s_req), 32'd0);
        check("hold_inst", s_inst,     32'h8C01_0004);
        check("hold_pc",   s_ipc,      32'h20);
        cycle(1'b0, 1'b0, 32'h0);
        check("hold_rel_valid", 32'(s_valid), 32'd1);
        check("hold_rel_inst",  s_inst,       32'h8C01_0004);
        check("hold_rel_req",   32'(s_req),   32'd0);
        cycle(1'b1, 1'b0, 32'h40);
        check("after_hold_addr", s_addr, 32'h24);

        wait_n = 2;
        cycle(1'b1, 1'b0, 32'h80);
        check("fw_addr0", s_addr,      32'h40);
        check("fw_sreq0", 32'(s_sreq), 32'd1);
        cycle(1'b0, 1'b0, 32'h0);
        check("fw_addr1", s_addr,      32'h40);
        cycle(1'b0, 1'b0, 32'h0);
        check("fw_ack_addr",  s_addr,       32'h40);
        check("fw_ack_valid", 32'(s_valid), 32'd0);
        cycle(1'b1, 1'b0, 32'h100);
        check("redirect_req",  32'(s_req), 32'd1);
        check("redirect_addr", s_addr,     32'h80);
        cycle(1'b0, 1'b0, 32'h0);
        check("disc_addr", s_addr,      32'h80);
        check("disc_sreq", 32'(s_sreq), 32'd1);
        do_reset(1);

        wait_n = 0;
        cycle(1'b0, 1'b1, 32'h0);
        check("hf_pre_valid", 32'(s_valid), 32'd1);
        cycle(1'b1, 1'b0, 32'h200);
        check("hf_valid", 32'(s_valid), 32'd0);
        check("hf_req",   32'(s_req),   32'd0);
        cycle(1'b0, 1'b0, 32'h0);
        check("hf_next_req",  32'(s_req), 32'd1);
        check("hf_next_addr", s_addr,     32'h200);

        last_pop = n_pop;
        idle_cyc = 0;
        for (int c = 0; c < 3000; c++) begin
            f  = !prev_flush && ($urandom_range(0, 19) == 0);
            s1 = ($urandom_range(0, 3) == 0);
            if (!out_v) wait_n = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 4));
            cycle(f, s1, {16'h0, 14'($urandom), 2'b00});
            if (n_pop != last_pop) begin
                last_pop = n_pop;
                idle_cyc = 0;
            end else begin
                idle_cyc++;
                if (idle_cyc > 200) begin
                    check("progress_timeout", 32'(idle_cyc), 32'd0);
                    break;
                end
            end
        end
        check("progress", 32'(n_pop > 300), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
